// File: rtl/step_sequencer.sv
// step_sequencer: per-step game controller for the snake datapath.
// Generates the move tick (pause/slow aware), scans body segments serially
// for self-collision, checks boundary and food, then issues one commit pulse.
// Optional feature: define SPEEDUP_EN to shorten the step period by
// STEP_DIV/16 on every food eaten, floored at STEP_DIV/4.
module step_sequencer #(
    parameter int STEP_DIV  = 12500000,
    parameter int SLOW_MULT = 2,
    parameter int MAX_LEN   = 64,
    parameter int LEN_W     = 6,
    parameter int CNT_W     = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       game_state,
    input  logic             pause,
    input  logic             slow,
    input  logic [LEN_W-1:0] snake_length,
    input  logic             seg_match,
    input  logic             bound_err,
    input  logic             food_match,
    output logic [LEN_W-1:0] seg_idx,
    output logic             step_move,
    output logic             grow,
    output logic             get_food,
    output logic             hit_self,
    output logic             hit_boundary,
    output logic             busy
);

    localparam logic [1:0]     GS_RUNNING = 2'b00;
    // One extra bit so MAX_LEN itself is representable even when LEN_W is tight.
    localparam logic [LEN_W:0] MAX_LEN_X  = (LEN_W+1)'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SCAN, S_FOOD, S_COMMIT, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] last_cnt;
    logic [LEN_W-1:0] seg_idx_nxt;
    logic             grow_r, grow_r_nxt;
    logic             step_nxt, grow_nxt, food_nxt;
    logic             hit_self_nxt, hit_bound_nxt, busy_nxt;

`ifdef SPEEDUP_EN
    localparam logic [CNT_W-1:0] BASE_INIT = CNT_W'(STEP_DIV);
    localparam logic [CNT_W-1:0] BASE_DEC  = CNT_W'(STEP_DIV / 16);
    localparam logic [CNT_W-1:0] BASE_MIN  = CNT_W'(STEP_DIV / 4);
    localparam logic [CNT_W-1:0] SLOW_K    = CNT_W'(SLOW_MULT);

    logic [CNT_W-1:0] base;

    // Floor-saturating decrement of the period base; base never drops below
    // BASE_MIN, which is itself >= BASE_DEC, so the subtraction cannot wrap.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] b);
        return (b < BASE_MIN + BASE_DEC) ? BASE_MIN : b - BASE_DEC;
    endfunction

    // Period base: reloads while idle, shrinks on each food commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            base <= BASE_INIT;
        else if (state == S_IDLE)
            base <= BASE_INIT;
        else if (state == S_COMMIT && grow_r)
            base <= sat_dec(base);
    end

    // Terminal count for the current period (slow scales the current base).
    always_comb last_cnt = slow ? (base * SLOW_K) - CNT_W'(1) : base - CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(STEP_DIV * SLOW_MULT - 1);

    // Terminal count for the current period.
    always_comb last_cnt = slow ? LAST_SLOW : LAST_NORM;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and registered-output decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        seg_idx_nxt   = seg_idx;
        grow_r_nxt    = grow_r;
        step_nxt      = 1'b0;
        grow_nxt      = 1'b0;
        food_nxt      = 1'b0;
        hit_self_nxt  = 1'b0;
        hit_bound_nxt = 1'b0;
        // Leaving RUNNING abandons any step in flight; HALT waits on its own.
        if (state != S_HALT && game_state != GS_RUNNING) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end
                S_WAIT: begin
                    if (!pause) begin
                        // >= so a period shortened by slow dropping fires at once.
                        if (cnt >= last_cnt) begin
                            cnt_nxt = '0;
                            if (bound_err) begin
                                hit_bound_nxt = 1'b1;
                                state_nxt     = S_HALT;
                            end else begin
                                seg_idx_nxt = LEN_W'(1);
                                state_nxt   = (snake_length <= LEN_W'(1)) ? S_FOOD : S_SCAN;
                            end
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                S_SCAN: begin
                    if (seg_match) begin
                        hit_self_nxt = 1'b1;
                        state_nxt    = S_HALT;
                    end else if (seg_idx == snake_length - LEN_W'(1)) begin
                        state_nxt = S_FOOD;
                    end else begin
                        seg_idx_nxt = seg_idx + LEN_W'(1);
                    end
                end
                S_FOOD: begin
                    grow_r_nxt = food_match && ({1'b0, snake_length} < MAX_LEN_X);
                    state_nxt  = S_COMMIT;
                end
                S_COMMIT: begin
                    step_nxt  = 1'b1;
                    grow_nxt  = grow_r;
                    food_nxt  = grow_r;
                    state_nxt = S_WAIT;
                end
                S_HALT: begin
                    if (game_state != GS_RUNNING)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        busy_nxt = (state_nxt == S_SCAN) || (state_nxt == S_FOOD) || (state_nxt == S_COMMIT);
    end

    // Counter, segment index and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            seg_idx      <= '0;
            grow_r       <= 1'b0;
            step_move    <= 1'b0;
            grow         <= 1'b0;
            get_food     <= 1'b0;
            hit_self     <= 1'b0;
            hit_boundary <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            seg_idx      <= seg_idx_nxt;
            grow_r       <= grow_r_nxt;
            step_move    <= step_nxt;
            grow         <= grow_nxt;
            get_food     <= food_nxt;
            hit_self     <= hit_self_nxt;
            hit_boundary <= hit_bound_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed stimulus for step_sequencer with an event-level
// reference model compared every cycle, plus hand-computed timing checks.
module tb_step_sequencer;

`ifdef SPEEDUP_EN
    localparam int TB_DIV = 64;
`else
    localparam int TB_DIV = 8;
`endif
    localparam int TB_MULT = 2;
    localparam int TB_MAX  = 8;
    localparam int TB_LW   = 4;
    localparam int TB_CW   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       game_state = 2'b10;
    logic             pause = 1'b0;
    logic             slow = 1'b0;
    logic [TB_LW-1:0] snake_length = 4'd3;
    logic             seg_match;
    logic             bound_err = 1'b0;
    logic             food_match = 1'b0;
    logic [TB_LW-1:0] seg_idx;
    logic             step_move, grow, get_food, hit_self, hit_boundary, busy;

    // Segment index that collides with the candidate head; 4'hF means none.
    logic [TB_LW-1:0] coll = 4'hF;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    step_sequencer #(
        .STEP_DIV (TB_DIV),
        .SLOW_MULT(TB_MULT),
        .MAX_LEN  (TB_MAX),
        .LEN_W    (TB_LW),
        .CNT_W    (TB_CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_state  (game_state),
        .pause       (pause),
        .slow        (slow),
        .snake_length(snake_length),
        .seg_match   (seg_match),
        .bound_err   (bound_err),
        .food_match  (food_match),
        .seg_idx     (seg_idx),
        .step_move   (step_move),
        .grow        (grow),
        .get_food    (get_food),
        .hit_self    (hit_self),
        .hit_boundary(hit_boundary),
        .busy        (busy)
    );

    // Datapath stand-in: the body comparator answers for the segment asked about.
    assign seg_match = (seg_idx == coll);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_STEP = 2, M_HALT = 3;
    int m_mode, m_waited, m_t, m_len, m_hit, m_seg, m_base, period;
    bit m_grow, e_step, e_grow, e_food, e_hs, e_hb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_waited = 0; m_seg = 0; m_base = TB_DIV; m_grow = 0;
            e_step = 0; e_grow = 0; e_food = 0; e_hs = 0; e_hb = 0;
        end else begin
            e_step = 0; e_grow = 0; e_food = 0; e_hs = 0; e_hb = 0;
            if (m_mode != M_HALT && game_state != 2'b00) begin
                m_mode = M_IDLE; m_waited = 0; m_base = TB_DIV;
            end else begin
                case (m_mode)
                    M_IDLE: begin m_mode = M_WAIT; m_waited = 0; end
                    M_WAIT: if (!pause) begin
                        period = slow ? m_base * TB_MULT : m_base;
                        if (m_waited + 1 >= period) begin
                            m_waited = 0;
                            if (bound_err) begin
                                e_hb = 1; m_mode = M_HALT;
                            end else begin
                                m_mode = M_STEP; m_t = 0; m_len = int'(snake_length); m_seg = 1;
                                m_hit = (m_len >= 2 && coll >= 1 && int'(coll) <= m_len - 1) ? int'(coll) : 0;
                            end
                        end else begin
                            m_waited++;
                        end
                    end
                    M_STEP: begin
                        m_t++;
                        if (m_hit != 0 && m_t == m_hit) begin
                            e_hs = 1; m_mode = M_HALT;
                        end else begin
                            if (m_len >= 2) m_seg = (1 + m_t < m_len - 1) ? 1 + m_t : m_len - 1;
                            if (m_t == m_len) m_grow = food_match && (m_len < TB_MAX);
                            if (m_t == m_len + 1) begin
                                e_step = 1; e_grow = m_grow; e_food = m_grow;
                                m_mode = M_WAIT; m_waited = 0;
`ifdef SPEEDUP_EN
                                if (m_grow) m_base = (m_base - TB_DIV/16 < TB_DIV/4) ? TB_DIV/4 : m_base - TB_DIV/16;
`endif
                            end
                        end
                    end
                    default: if (game_state != 2'b00) m_mode = M_IDLE;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("step_move",    int'(step_move),    int'(e_step));
            check("grow",         int'(grow),         int'(e_grow));
            check("get_food",     int'(get_food),     int'(e_food));
            check("hit_self",     int'(hit_self),     int'(e_hs));
            check("hit_boundary", int'(hit_boundary), int'(e_hb));
            check("busy",         int'(busy),         int'(m_mode == M_STEP));
            check("seg_idx",      int'(seg_idx),      m_seg);
        end
    end

    // which: 0 step_move, 1 hit_self, 2 hit_boundary. Returns the cycle seen.
    task automatic wait_pulse(input int which, input int budget, output int at);
        bit s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            s = (which == 0) ? step_move : (which == 1) ? hit_self : hit_boundary;
            if (s) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_pulse%0d: no pulse within %0d cycles", which, budget);
        end
    endtask

    task automatic count_steps(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (step_move) n++;
        end
    endtask

    initial begin
        int k0, s, s2, n;
        repeat (2) @(negedge clk);
        check("rst_step_move", int'(step_move), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_seg_idx",   int'(seg_idx), 0);
        check("rst_pulses",    int'(grow | get_food | hit_self | hit_boundary), 0);
        rst = 1'b0;
        @(negedge clk);
`ifdef SPEEDUP_EN
        snake_length = 4'd2; food_match = 1'b1;
        game_state = 2'b00; k0 = cyc + 1;
        wait_pulse(0, 200, s);
        check("sp_first_step", s - k0, 64 + 3);
        for (int i = 0; i < 14; i++) begin
            wait_pulse(0, 200, s2);
            check("sp_spacing", s2 - s, ((64 - 4*(i+1) < 16) ? 16 : 64 - 4*(i+1)) + 3);
            s = s2;
        end
`else
        // Basic stepping, length 3.
        game_state = 2'b00; k0 = cyc + 1;
        repeat (9) @(negedge clk);
        check("tick_seg1", int'(seg_idx), 1);
        check("tick_busy", int'(busy), 1);
        @(negedge clk);
        check("scan_seg2", int'(seg_idx), 2);
        wait_pulse(0, 30, s);
        check("first_step_lat", s - k0, 12);
        check("first_grow", int'(grow), 0);
        wait_pulse(0, 30, s2);
        check("step_period", s2 - s, 12);
        // Pause for 5 cycles mid-WAIT.
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        wait_pulse(0, 40, s);
        check("pause_delay", s - s2, 17);
        // Slow period.
        slow = 1'b1;
        wait_pulse(0, 40, s2);
        check("slow_period1", s2 - s, 20);
        wait_pulse(0, 40, s);
        check("slow_period2", s - s2, 20);
        slow = 1'b0;
        // Self collision at segment 2 of 4.
        snake_length = 4'd4; coll = 4'd2;
        wait_pulse(1, 30, s2);
        check("hit_self_lat", s2 - s, 10);
        count_steps(10, n);
        check("halt_no_step", n, 0);
        game_state = 2'b01; coll = 4'hF;
        @(negedge clk);
        check("die_busy", int'(busy), 0);
        // Boundary violation at the tick.
        bound_err = 1'b1; game_state = 2'b00; k0 = cyc + 1;
        wait_pulse(2, 30, s);
        check("hit_bound_lat", s - k0, 8);
        count_steps(6, n);
        check("bound_no_step", n, 0);
        game_state = 2'b01;
        @(negedge clk);
        // Food at length 5.
        bound_err = 1'b0; game_state = 2'b00; snake_length = 4'd5; food_match = 1'b1;
        k0 = cyc + 1;
        wait_pulse(0, 40, s);
        check("food_lat", s - k0, 14);
        check("food_grow", int'(grow), 1);
        check("food_get", int'(get_food), 1);
        // Food at MAX_LEN.
        snake_length = 4'd8;
        wait_pulse(0, 40, s2);
        check("max_lat", s2 - s, 17);
        check("max_grow", int'(grow), 0);
        check("max_get", int'(get_food), 0);
        // Abort during SCAN.
        food_match = 1'b0;
        repeat (10) @(negedge clk);
        game_state = 2'b10;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        count_steps(20, n);
        check("abort_no_step", n, 0);
        // Reset in the middle of a step.
        game_state = 2'b00; snake_length = 4'd3;
        n = 0;
        for (int i = 0; i < 30 && !busy; i++) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_seg", int'(seg_idx), 0);
        @(negedge clk);
        rst = 1'b0; k0 = cyc + 1;
        wait_pulse(0, 30, s);
        check("post_rst_lat", s - k0, 12);
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
